regfile_clr: RTL and testbench
==============================

Name: regfile_clr

Overview:
- Register file: the responder for the ID stage's two read-request ports, and the sink for the write-back port.
- 32 x 32-bit general registers. $0 is hard-wired to zero.
- Two combinational read ports with same-cycle write-to-read bypass. One synchronous write port.
- Storage has no direct reset, so it can map to distributed/block RAM. A post-reset sweep FSM zeroes registers $1..$31 before reporting ready to the pipeline.

Parameters:
- DATA_W, 32, register width (RegBus).
- ADDR_W, 5, register address width (RegAddrBus).
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- we  in  1  write enable from WB.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re1  in  1  read enable, port 1 (driven by ID reg1_read).
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1 (combinational).
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2 (combinational).
- ready_o  out  1  registered; 1 = sweep done, ports live.
- wdrop_o  out  1  registered one-cycle pulse: a write was discarded.

Behaviour:
- State register: CLEAR or RUN. Sweep index clr_idx is ADDR_W bits wide.
- Edge with rst=0:
  - state<=CLEAR, clr_idx<=1, ready_o<=0, wdrop_o<=0.
  - Storage is untouched. Reset may be held for any number of cycles.
- CLEAR, each edge with rst=1:
  - mem[clr_idx]<=0, then clr_idx<=clr_idx+1.
  - On the edge that writes clr_idx==NUM_REGS-1: state<=RUN, ready_o<=1.
  - Result: ready_o rises after the 31st edge following rst release. Latency 31 cycles, independent of prior contents.
- CLEAR, writes: port writes are ignored. If we=1 and waddr!=0, wdrop_o<=1 for one cycle.
- RUN, writes: if we=1 and waddr!=0, mem[waddr]<=wdata at the edge. Writes to $0 are discarded silently (no wdrop_o). wdrop_o<=0 otherwise.
- Read port n, combinational, priority order:
  1. rst=0, or ready_o=0, or ren=0, or raddrn==0 -> 0.
  2. we=1 and waddr==raddrn -> wdata (bypass; the write lands at the next edge).
  3. Otherwise mem[raddrn].
- Both read ports may name the same register, and may also match waddr. Both return the same value under the same rules.
- Reset mid-RUN: returns to CLEAR on that edge, ready_o falls, and all registers are re-zeroed by a full sweep.
- Reset mid-CLEAR: the sweep restarts at $1.
- No X may propagate: after ready_o=1, every register reads 0 until written.
- clr_idx never wraps in RUN. It is frozen at NUM_REGS-1 and reloaded only by reset.

Test Plan:
- Preload mem with 0xDEADBEEF (backdoor), pulse rst=0 for 2 cycles -> ready_o=0 for exactly 31 edges after release then 1; reads of $1..$31 return 0x00000000; rdata=0 throughout CLEAR.
- RUN: we=1 waddr=5 wdata=0x12345678; next cycle re1=1 raddr1=5 -> rdata1=0x12345678. Same cycle re2=1 raddr2=5 with we=1 wdata=0xAAAA5555 -> rdata2=0xAAAA5555 (bypass). The following cycle, with we=0, rdata2=0xAAAA5555.
- we=1 waddr=0 wdata=0xFFFFFFFF, then read $0 on both ports -> 0; bypass not applied to $0; wdrop_o stays 0.
- re1=0 raddr1=5 (holding 0x12345678) -> rdata1=0. re2=1 raddr2=5 simultaneously -> 0x12345678.
- During CLEAR, cycle 10: we=1 waddr=7 wdata=0x55 -> wdrop_o=1 for one cycle; after ready_o, $7 reads 0.
- In RUN with $3=0x33, assert rst=0 one cycle at sweep index 20 of a second reset, release -> full 31-cycle sweep restarts; $3 reads 0 once ready_o=1.

Source files
------------

// File: rtl/regfile_clr.sv
// 32 x 32 register file with $0 tied to zero, two bypassed combinational read ports,
// one write port. Storage has no reset; a sweep after reset zeroes $1..$31 before ready_o rises.
module regfile_clr #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              ready_o,
    output logic              wdrop_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_next;
    logic              ready_next;
    logic              wdrop_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [NUM_REGS];

    // The sweep and the write-back port share the single RAM write port; CLEAR owns it.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        ready_next   = ready_o;
        wdrop_next   = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = waddr;
        mem_wdata    = wdata;
        case (state)
            CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_idx;
                mem_wdata  = '0;
                wdrop_next = we && (waddr != '0);
                if (clr_idx == LAST_IDX) begin
                    state_next = RUN;
                    ready_next = 1'b1;
                end else begin
                    clr_idx_next = clr_idx + ADDR_W'(1);
                end
            end
            RUN: begin
                mem_we = we && (waddr != '0);
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= ADDR_W'(1);
            ready_o <= 1'b0;
            wdrop_o <= 1'b0;
        end else begin
            state   <= state_next;
            clr_idx <= clr_idx_next;
            ready_o <= ready_next;
            wdrop_o <= wdrop_next;
        end
    end

    // No reset on the array so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst && ready_o && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && ready_o && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem[raddr2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_clr.sv
// Self-checking bench for regfile_clr: expected read data is queued when stimulus
// is driven and popped when the combinational outputs are sampled.
module tb_regfile_clr;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        ready_o;
    logic        wdrop_o;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] model [32];

    regfile_clr #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .ready_o(ready_o),
        .wdrop_o(wdrop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_ports(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                             input logic r1, input logic [4:0] a1,
                             input logic r2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Reset with garbage already in storage; ready must rise on exactly the 31st edge.
    task automatic test_reset();
        for (int i = 0; i < 32; i++) dut.mem[i] = 32'hDEADBEEF;
        rst = 1'b0;
        set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 0", ready_o); end
        n_cmp++;
        if (wdrop_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wdrop: got %b want 0", wdrop_o); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            raddr1 = 5'(k);
            raddr2 = 5'(32 - k);
            exp_q.push_back(32'h0);
            #2;
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL clear_rd1 k=%0d: got %h want %h", k, rdata1, exp); end
            @(posedge clk);
            #1;
            n_cmp++;
            if (ready_o !== (k == 31)) begin
                n_fail++;
                $display("[TB] FAIL ready_latency edge=%0d: got %b want %b", k, ready_o, (k == 31));
            end
            @(negedge clk);
        end
        clear_model();
        for (int r = 1; r < 32; r++) begin
            set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 1'b1, 5'(r));
            exp_q.push_back(model[r]);
            exp_q.push_back(model[r]);
            #2;
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL swept_rd1 r=%0d: got %h want %h", r, rdata1, exp); end
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL swept_rd2 r=%0d: got %h want %h", r, rdata2, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_write_bypass();
        set_ports(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        model[5] = 32'h12345678;
        @(negedge clk);
        set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5);
        exp_q.push_back(model[5]);
        exp_q.push_back(32'h0);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL wr_rd1: got %h want %h", rdata1, exp); end
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL re2_off: got %h want %h", rdata2, exp); end
        @(negedge clk);
        set_ports(1'b1, 5'd5, 32'hAAAA5555, 1'b1, 5'd5, 1'b1, 5'd5);
        exp_q.push_back(32'hAAAA5555);
        exp_q.push_back(32'hAAAA5555);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL bypass_rd1: got %h want %h", rdata1, exp); end
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL bypass_rd2: got %h want %h", rdata2, exp); end
        @(posedge clk);
        model[5] = 32'hAAAA5555;
        @(negedge clk);
        set_ports(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd5);
        exp_q.push_back(model[5]);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL after_bypass_rd2: got %h want %h", rdata2, exp); end
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        set_ports(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL zero_bypass_rd1: got %h want %h", rdata1, exp); end
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL zero_bypass_rd2: got %h want %h", rdata2, exp); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (wdrop_o !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_wdrop: got %b want 0", wdrop_o); end
        @(negedge clk);
        set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        exp_q.push_back(32'h0);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if ((rdata1 | rdata2) !== exp) begin
            n_fail++;
            $display("[TB] FAIL zero_read: got %h/%h want %h", rdata1, rdata2, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_read_enable();
        set_ports(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        model[5] = 32'h12345678;
        @(negedge clk);
        set_ports(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5);
        exp_q.push_back(32'h0);
        exp_q.push_back(model[5]);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL re1_off: got %h want %h", rdata1, exp); end
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL re2_on: got %h want %h", rdata2, exp); end
        @(negedge clk);
    endtask

    // Consecutive writes: port 1 reads the previous register from storage, port 2 bypasses.
    task automatic test_back_to_back();
        for (int i = 10; i < 16; i++) begin
            set_ports(1'b1, 5'(i), 32'hC0DE0000 + 32'(i * 17), 1'b1, 5'(i - 1), 1'b1, 5'(i));
            exp_q.push_back(model[i - 1]);
            exp_q.push_back(32'hC0DE0000 + 32'(i * 17));
            #2;
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL b2b_rd1 i=%0d: got %h want %h", i, rdata1, exp); end
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL b2b_rd2 i=%0d: got %h want %h", i, rdata2, exp); end
            @(posedge clk);
            model[i] = 32'hC0DE0000 + 32'(i * 17);
            @(negedge clk);
        end
        for (int i = 9; i < 17; i++) begin
            set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(25 - i));
            exp_q.push_back(model[i]);
            exp_q.push_back(model[25 - i]);
            #2;
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL b2b_read1 i=%0d: got %h want %h", i, rdata1, exp); end
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL b2b_read2 i=%0d: got %h want %h", i, rdata2, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_clear_wdrop();
        set_ports(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        model[7] = 32'h77;
        @(negedge clk);
        rst = 1'b0;
        set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_fall: got %b want 0", ready_o); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            set_ports(k == 10, 5'd7, 32'h55, 1'b1, 5'd7, 1'b1, 5'd7);
            if (k == 3) begin
                exp_q.push_back(32'h0);
                #2;
                exp = exp_q.pop_front();
                n_cmp++;
                if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL clear_gate_rd1: got %h want %h", rdata1, exp); end
            end
            @(posedge clk);
            #1;
            if (k == 10) begin
                n_cmp++;
                if (wdrop_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wdrop_pulse: got %b want 1", wdrop_o); end
            end
            if (k == 11) begin
                n_cmp++;
                if (wdrop_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wdrop_end: got %b want 0", wdrop_o); end
            end
            if (k >= 30) begin
                n_cmp++;
                if (ready_o !== (k == 31)) begin
                    n_fail++;
                    $display("[TB] FAIL wdrop_ready edge=%0d: got %b want %b", k, ready_o, (k == 31));
                end
            end
            @(negedge clk);
        end
        clear_model();
        set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        exp_q.push_back(model[7]);
        exp_q.push_back(model[7]);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL dropped_rd1: got %h want %h", rdata1, exp); end
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL dropped_rd2: got %h want %h", rdata2, exp); end
        @(negedge clk);
    endtask

    // A reset landing mid-sweep restarts it from $1 with the full latency.
    task automatic test_reset_mid_sweep();
        int cycles;
        set_ports(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clk);
        model[3] = 32'h33;
        @(negedge clk);
        set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
        exp_q.push_back(model[3]);
        #2;
        exp = exp_q.pop_front();
        n_cmp++;
        if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL pre_reset_rd1: got %h want %h", rdata1, exp); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_ready: got %b want 0", ready_o); end
        @(negedge clk);
        rst = 1'b1;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!ready_o && cycles < 64);
        n_cmp++;
        if (cycles !== 31) begin n_fail++; $display("[TB] FAIL restart_latency: got %0d want 31", cycles); end
        clear_model();
        for (int r = 1; r < 32; r += 5) begin
            @(negedge clk);
            set_ports(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'(r));
            exp_q.push_back(model[3]);
            exp_q.push_back(model[r]);
            #2;
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata1 !== exp) begin n_fail++; $display("[TB] FAIL restart_rd1: got %h want %h", rdata1, exp); end
            exp = exp_q.pop_front();
            n_cmp++;
            if (rdata2 !== exp) begin n_fail++; $display("[TB] FAIL restart_rd2 r=%0d: got %h want %h", r, rdata2, exp); end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear_model();
        test_reset();
        test_write_bypass();
        test_zero_reg();
        test_read_enable();
        test_back_to_back();
        test_clear_wdrop();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
